// File: rtl/cache_fifo_drain.sv
// Drains a show-ahead FIFO into valid/ready bursts of up to BURST_LEN beats, started on fill, idle timeout or flush.
// First beat 2 cycles after the start condition; pops stall only on cycles where out_valid is held without out_ready.
module cache_fifo_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        soft_rst,
    output logic                        fifo_read,
    input  logic [DATA_WIDTH-1:0]       fifo_read_data,
    input  logic                        fifo_empty,
    input  logic [$clog2(FIFO_DEPTH):0] fifo_data_num,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        flush_done,
    output logic                        busy
);
    localparam int NUM_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [NUM_W-1:0] BURST_LEN_N = NUM_W'(BURST_LEN);
    localparam logic [TMR_W-1:0] TIMEOUT_T   = TMR_W'(TIMEOUT);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [NUM_W-1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   flush_pending_q, flush_pending_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   clr;
    logic                   timeout_hit;

    assign clr         = rst | soft_rst;
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMEOUT_T);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        timer_d         = timer_q;
        flush_pending_d = flush_pending_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_last_d      = out_last_q;
        fifo_read       = 1'b0;
        flush_done      = 1'b0;

        // Flush completes only once everything buffered has left through the output.
        if (flush_pending_q && state_q == IDLE && fifo_empty && !out_valid_q) begin
            flush_done      = 1'b1;
            flush_pending_d = 1'b0;
        end else if (flush) begin
            flush_pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fifo_data_num >= BURST_LEN_N) begin
                    state_d = BURST;
                    cnt_d   = BURST_LEN_N;
                    timer_d = '0;
                end else if (!fifo_empty && (flush_pending_q || timeout_hit)) begin
                    state_d = BURST;
                    cnt_d   = fifo_data_num;
                    timer_d = '0;
                end else if (fifo_empty) begin
                    timer_d = '0;
                end else if (timer_q != TIMEOUT_T) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            BURST: begin
                timer_d   = '0;
                fifo_read = (cnt_q != '0) && (!out_valid_q || out_ready);
                if (fifo_read) begin
                    out_data_d  = fifo_read_data;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q - NUM_W'(1);
                    out_last_d  = (cnt_q == NUM_W'(1));
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset wins over everything, including the combinational strobes.
        if (clr) begin
            fifo_read  = 1'b0;
            flush_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            timer_q         <= '0;
            flush_pending_q <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_last_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            timer_q         <= timer_d;
            flush_pending_q <= flush_pending_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_last_q      <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == BURST) || out_valid_q;

endmodule

// File: tb/tb_cache_fifo_drain.sv
// Directed bench for cache_fifo_drain: a behavioural show-ahead FIFO feeds the main instance,
// a second instance with TIMEOUT = 0 sits on a static two-entry FIFO image.
module tb_cache_fifo_drain;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, soft_rst, flush, out_ready, wr_en;
    logic [31:0] wr_data;
    logic        fifo_read, fifo_empty, out_valid, out_last, busy, flush_done;
    logic [31:0] fifo_read_data, out_data;
    logic [4:0]  fifo_data_num;

    logic        rst2, flush2, fifo_read2, out_valid2, out_last2, busy2, flush_done2;
    logic [31:0] out_data2;
    logic [31:0] fifo_read_data2 = 32'h55;
    logic        fifo_empty2 = 1'b0;
    logic [4:0]  fifo_data_num2 = 5'd2;
    logic        soft_rst2 = 1'b0;
    logic        out_ready2 = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    int rd_count = 0;
    logic [31:0] log_dat[$];
    logic        log_last[$];

    cache_fifo_drain #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .BURST_LEN(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .fifo_read(fifo_read),
        .fifo_read_data(fifo_read_data), .fifo_empty(fifo_empty), .fifo_data_num(fifo_data_num),
        .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .flush_done(flush_done), .busy(busy));

    cache_fifo_drain #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .BURST_LEN(4), .TIMEOUT(0)) dut_t0 (
        .clk(clk), .rst(rst2), .soft_rst(soft_rst2), .fifo_read(fifo_read2),
        .fifo_read_data(fifo_read_data2), .fifo_empty(fifo_empty2), .fifo_data_num(fifo_data_num2),
        .flush(flush2), .out_valid(out_valid2), .out_data(out_data2), .out_last(out_last2),
        .out_ready(out_ready2), .flush_done(flush_done2), .busy(busy2));

    // Behavioural synchronous FIFO, show-ahead read port, cleared together with the drain block.
    logic [31:0] mem [16];
    logic [3:0]  wp, rp;
    logic [4:0]  cnt;
    always @(posedge clk) begin
        if (rst || soft_rst) begin
            wp <= '0; rp <= '0; cnt <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp <= wp + 4'd1;
            end
            if (fifo_read) rp <= rp + 4'd1;
            cnt <= cnt + {4'b0, wr_en} - {4'b0, fifo_read};
        end
    end
    assign fifo_empty     = (cnt == 5'd0);
    assign fifo_data_num  = cnt;
    assign fifo_read_data = mem[rp];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle protocol checks and beat logging, sampled mid-cycle.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_dat;
    logic        prev_last;
    always @(negedge clk) begin
        if (!(rst || soft_rst)) begin
            if (fifo_empty) chk("pop_while_empty", {31'b0, fifo_read}, 32'd0);
            if (out_valid && !out_ready) chk("pop_while_stalled", {31'b0, fifo_read}, 32'd0);
            if (stall_prev) chk("stall_hold", {out_valid, out_last, out_data == prev_dat},
                                {1'b1, prev_last, 1'b1});
            if (out_valid && out_ready) begin
                log_dat.push_back(out_data);
                log_last.push_back(out_last);
            end
            if (fifo_read) rd_count++;
            stall_prev = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_last  = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    int cycn = 0;
    task automatic cyc(input logic w, input logic [31:0] d, input logic rdy, input logic fl, input logic sr);
        @(posedge clk);
        #1;
        wr_en = w; wr_data = d; out_ready = rdy; flush = fl; soft_rst = sr;
        cycn++;
        #1;
    endtask

    task automatic wait_beats(input int target);
        for (int i = 0; i < 200 && log_dat.size() < target; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_beats(input string nm, input int base, input int n, input logic [31:0] d0, input int blen);
        chk({nm, "_count"}, log_dat.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < log_dat.size()) begin
                chk({nm, "_dat"}, log_dat[base+i], d0 + i);
                chk({nm, "_last"}, {31'b0, log_last[base+i]},
                    ((i % blen == blen - 1) || (i == n - 1)) ? 32'd1 : 32'd0);
            end
        end
    endtask

    task automatic settle();
        repeat (3) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic w; logic [31:0] d; logic rdy; logic fl;
        logic e_rd; logic e_vld; logic [31:0] e_dat; logic e_last; logic e_busy; logic e_done;
    } vec_t;
    vec_t tv [14];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rd0, n, done_at, last_hs;
        logic r, got, bad;

        tv[0]  = '{1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 32'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b0};
        tv[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        tv[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        tv[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1};
        tv[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};

        rst = 1'b1; soft_rst = 1'b0; flush = 1'b0; out_ready = 1'b1; wr_en = 1'b0; wr_data = '0;
        rst2 = 1'b1; flush2 = 1'b0;
        repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_fifo_read", {31'b0, fifo_read}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_flush_done", {31'b0, flush_done}, 32'd0);

        // Full 4-beat burst, then flush of an already-empty FIFO.
        rd0 = rd_count;
        for (int i = 0; i < 14; i++) begin
            cyc(tv[i].w, tv[i].d, tv[i].rdy, tv[i].fl, 1'b0);
            chk($sformatf("tv%0d_fifo_read", i), {31'b0, fifo_read}, {31'b0, tv[i].e_rd});
            chk($sformatf("tv%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tv[i].e_vld});
            chk($sformatf("tv%0d_busy", i), {31'b0, busy}, {31'b0, tv[i].e_busy});
            chk($sformatf("tv%0d_flush_done", i), {31'b0, flush_done}, {31'b0, tv[i].e_done});
            if (tv[i].e_vld) begin
                chk($sformatf("tv%0d_out_data", i), out_data, tv[i].e_dat);
                chk($sformatf("tv%0d_out_last", i), {31'b0, out_last}, {31'b0, tv[i].e_last});
            end
        end
        chk("full_read_count", rd_count - rd0, 32'd4);
        chk("full_fifo_empty", {31'b0, fifo_empty}, 32'd1);

        // Backpressure: out_ready toggles every cycle over two 4-beat bursts.
        base = log_dat.size(); rd0 = rd_count; r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'hB0 + i, r, 1'b0, 1'b0);
            r = ~r;
        end
        for (int i = 0; i < 200 && log_dat.size() < base + 8; i++) begin
            cyc(1'b0, 32'd0, r, 1'b0, 1'b0);
            r = ~r;
        end
        settle();
        chk_beats("bp", base, 8, 32'hB0, 4);
        chk("bp_read_count", rd_count - rd0, 32'd8);

        // Idle timeout on a 2-entry partial batch.
        base = log_dat.size();
        cyc(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hC1, 1'b1, 1'b0, 1'b0);
        chk("to_empty_fell", {31'b0, fifo_empty}, 32'd0);
        n = 0; got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            n++;
            if (fifo_read) got = 1'b1;
        end
        chk("to_first_pop_delay", n, 32'd9);
        wait_beats(base + 2);
        settle();
        chk_beats("to", base, 2, 32'hC0, 4);

        // Flush with 3 buffered entries.
        base = log_dat.size();
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hD0 + i, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        done_at = -1; last_hs = -100; got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            if (flush_done) begin
                done_at = cycn;
                got = 1'b1;
            end
            if (out_valid && out_ready && out_last) last_hs = cycn;
        end
        chk("fl_done_after_last", done_at, last_hs + 1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("fl_done_one_cycle", {31'b0, flush_done}, 32'd0);
        chk_beats("fl", base, 3, 32'hD0, 4);

        // Continuous writes while draining.
        base = log_dat.size(); rd0 = rd_count;
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'hE0 + i, 1'b1, 1'b0, 1'b0);
        wait_beats(base + 16);
        settle();
        chk_beats("wdb", base, 16, 32'hE0, 4);
        chk("wdb_read_count", rd_count - rd0, 32'd16);
        chk("wdb_fifo_empty", {31'b0, fifo_empty}, 32'd1);

        // soft_rst while beat 2 is presented, then a clean burst.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hF0 + i, 1'b1, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            if (out_valid && out_data == 32'hF1) got = 1'b1;
        end
        chk("sr_beat2_seen", {31'b0, got}, 32'd1);
        soft_rst = 1'b1;
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("sr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("sr_busy", {31'b0, busy}, 32'd0);
        chk("sr_fifo_read", {31'b0, fifo_read}, 32'd0);
        base = log_dat.size();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h10 + i, 1'b1, 1'b0, 1'b0);
        wait_beats(base + 4);
        settle();
        chk_beats("sr", base, 4, 32'h10, 4);

        // TIMEOUT = 0: two entries sit forever until a flush.
        rst2 = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            if (fifo_read2 || out_valid2 || busy2 || out_last2 || flush_done2 || out_data2 != 32'd0) bad = 1'b1;
        end
        chk("t0_no_burst", {31'b0, bad}, 32'd0);
        flush2 = 1'b1;
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        flush2 = 1'b0;
        chk("t0_flush_wait", {31'b0, fifo_read2}, 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("t0_flush_pop", {31'b0, fifo_read2}, 32'd1);
        rst2 = 1'b1;
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
